// File: rtl/lifo_stack_tos_cache.sv
// Operand stack with top-of-stack and next-on-stack cached in registers so
// both ALU operands are available with zero latency; deeper entries spill to an array.
module lifo_stack_tos_cache #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic [2:0]        OP,
  input  logic [DATA_W-1:0] I_DATA,
  output logic              O_VALID,
  output logic [DATA_W-1:0] O_DATA,
  output logic [DATA_W-1:0] TOS,
  output logic [DATA_W-1:0] NOS,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVF,
  output logic              UDF
);

  localparam int ARR_N = DEPTH - 2;
  localparam int AW    = (ARR_N > 1) ? $clog2(ARR_N) : 1;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_DUP     = 3'd4;
  localparam logic [2:0] OP_SWAP    = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [0:ARR_N-1];

  logic [DATA_W-1:0] tos_q, tos_n;
  logic [DATA_W-1:0] nos_q, nos_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DATA_W-1:0] od_q, od_n;
  logic              ov_q, ov_n;
  logic              ovf_q, ovf_n;
  logic              udf_q, udf_n;

  logic              mem_we;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [CNT_W-1:0]  wr_full_idx;
  logic [CNT_W-1:0]  rd_full_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] refill;

  logic is_full, is_empty, ge2, ge3;

  assign is_full  = (cnt_q == CNT_FULL);
  assign is_empty = (cnt_q == '0);
  assign ge2      = (cnt_q >= CNT_TWO);
  assign ge3      = (cnt_q >= CNT_THREE);

  // Spill writes land one slot below NOS; refills read the slot below that.
  assign wr_full_idx = cnt_q - CNT_TWO;
  assign rd_full_idx = cnt_q - CNT_THREE;
  assign wr_idx      = wr_full_idx[AW-1:0];
  assign rd_idx      = rd_full_idx[AW-1:0];
  assign rd_data     = mem[rd_idx];
  assign refill      = ge3 ? rd_data : '0;

  always_comb begin
    tos_n  = tos_q;
    nos_n  = nos_q;
    cnt_n  = cnt_q;
    od_n   = od_q;
    ov_n   = 1'b0;
    ovf_n  = ovf_q;
    udf_n  = udf_q;
    mem_we = 1'b0;
    if (CLR) begin
      tos_n = '0;
      nos_n = '0;
      cnt_n = '0;
      od_n  = '0;
      ovf_n = 1'b0;
      udf_n = 1'b0;
    end else begin
      case (OP)
        OP_PUSH: begin
          if (is_full) begin
            ovf_n = 1'b1;
          end else begin
            tos_n  = I_DATA;
            nos_n  = tos_q;
            mem_we = ge2;
            cnt_n  = cnt_q + CNT_ONE;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            udf_n = 1'b1;
          end else begin
            od_n  = tos_q;
            ov_n  = 1'b1;
            tos_n = nos_q;
            nos_n = refill;
            cnt_n = cnt_q - CNT_ONE;
          end
        end
        OP_REPLACE: begin
          if (!ge2) begin
            udf_n = 1'b1;
          end else begin
            tos_n = I_DATA;
            nos_n = refill;
            cnt_n = cnt_q - CNT_ONE;
          end
        end
        OP_DUP: begin
          if (is_empty) begin
            udf_n = 1'b1;
          end else if (is_full) begin
            ovf_n = 1'b1;
          end else begin
            nos_n  = tos_q;
            mem_we = ge2;
            cnt_n  = cnt_q + CNT_ONE;
          end
        end
        OP_SWAP: begin
          if (!ge2) begin
            udf_n = 1'b1;
          end else begin
            tos_n = nos_q;
            nos_n = tos_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tos_q <= '0;
      nos_q <= '0;
      cnt_q <= '0;
      od_q  <= '0;
      ov_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tos_q <= tos_n;
      nos_q <= nos_n;
      cnt_q <= cnt_n;
      od_q  <= od_n;
      ov_q  <= ov_n;
      ovf_q <= ovf_n;
      udf_q <= udf_n;
    end
  end

  // Array contents are deliberately not reset; gate the write with RST so an
  // op in flight when reset arrives leaves nothing behind.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem[wr_idx] <= nos_q;
    end
  end

  assign TOS     = tos_q;
  assign NOS     = nos_q;
  assign COUNT   = cnt_q;
  assign O_DATA  = od_q;
  assign O_VALID = ov_q;
  assign OVF     = ovf_q;
  assign UDF     = udf_q;
  assign FULL    = is_full;
  assign EMPTY   = is_empty;

endmodule

// File: doc/lifo_stack_tos_cache.md
Name: lifo_stack_tos_cache

Overview:
- Parametrised hardware stack for the stack-machine datapath: generalised DATA_W/DEPTH successor of the 8-bit 1024-entry operand LIFO.
- Top-of-stack (TOS) and next-on-stack (NOS) are held in registers, so the ALU reads both operands with zero latency; deeper entries live in an array.
- Adds DUP/SWAP/REPLACE operations, an occupancy count, sticky overflow/underflow flags and a synchronous clear.

Parameters:
- DATA_W, 8, entry width in bits.
- DEPTH, 1024, total capacity in entries (TOS + NOS + array); legal range DEPTH >= 4; array holds DEPTH-2 entries.
- CNT_W, $clog2(DEPTH+1), localparam; width of COUNT.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- CLR  in  1  synchronous clear: empties the stack, clears flags; priority over OP.
- OP  in  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 DUP, 5 SWAP, 6/7 reserved (treated as NOP).
- I_DATA  in  DATA_W  operand for PUSH/REPLACE.
- O_VALID  out  1  registered; high for one cycle after a successful POP.
- O_DATA  out  DATA_W  registered popped value; holds the last value when O_VALID is low.
- TOS  out  DATA_W  registered top entry; 0 when COUNT==0.
- NOS  out  DATA_W  registered second entry; 0 when COUNT<2.
- COUNT  out  CNT_W  current occupancy, 0..DEPTH.
- FULL  out  1  combinational: COUNT==DEPTH.
- EMPTY  out  1  combinational: COUNT==0.
- OVF  out  1  sticky: an op was refused for lack of space.
- UDF  out  1  sticky: an op was refused for lack of operands.

Behaviour:
- Reset (async, RST=1): COUNT=0, TOS=0, NOS=0, O_VALID=0, O_DATA=0, OVF=0, UDF=0. Array contents are not reset. Reset asserted mid-operation aborts that operation; no partial update survives.
- CLR=1: same register values as reset on the next edge; OP is ignored that cycle.
- Storage: array entry k (0-based) holds stack position k from the bottom; the array is written at index COUNT-2 and read at index COUNT-3. Array read may be asynchronous (distributed RAM).
- PUSH (COUNT<DEPTH):
  - TOS<=I_DATA, NOS<=old TOS.
  - If COUNT>=2, array[COUNT-2]<=old NOS.
  - COUNT+1.
- PUSH with FULL: no state change except OVF<=1.
- POP (COUNT>=1):
  - O_DATA<=TOS, O_VALID<=1.
  - TOS<=NOS (0 if COUNT==1).
  - NOS<=array[COUNT-3] if COUNT>=3, else 0.
  - COUNT-1.
- POP with EMPTY: UDF<=1; O_VALID<=0; no other change.
- REPLACE (binary-op writeback; COUNT>=2):
  - TOS<=I_DATA.
  - NOS<=array[COUNT-3] if COUNT>=3, else 0.
  - COUNT-1; O_VALID<=0.
  - If COUNT<2: UDF<=1, no other change.
- DUP (1<=COUNT<DEPTH):
  - NOS<=TOS, TOS unchanged.
  - If COUNT>=2, array[COUNT-2]<=NOS.
  - COUNT+1.
  - COUNT==0: UDF<=1. FULL: OVF<=1. No other change in either case.
- SWAP (COUNT>=2): TOS<=NOS, NOS<=TOS; COUNT unchanged. If COUNT<2: UDF<=1, no other change.
- O_VALID is low on every cycle other than the one following a successful POP.
- Exactly one op per cycle, with single-cycle latency: outputs reflect the op on the edge after it is presented.
- Back-to-back ops on consecutive cycles are legal and must each see the updated state.
- COUNT arithmetic is unsigned, CNT_W bits wide, and never wraps: guards above prevent the transitions 0->-1 and DEPTH->DEPTH+1.
- OVF/UDF remain set until RST or CLR.

Test Plan:
- Reset then PUSH 0x11, 0x22, 0x33 -> TOS=0x33, NOS=0x22, COUNT=3; POP x3 -> O_DATA 0x33, 0x22, 0x11 each with O_VALID pulse; EMPTY=1, TOS=NOS=0.
- DEPTH=4: PUSH 1,2,3,4 -> FULL=1; PUSH 5 -> OVF=1, COUNT=4, TOS=4; POP x4 returns 4,3,2,1 (array path exercised).
- Empty stack: POP, SWAP, REPLACE, DUP in turn -> UDF=1, COUNT=0, O_VALID stays 0; CLR -> UDF=0.
- Stack 5,7,9 (TOS=9): REPLACE I_DATA=0x10 -> TOS=0x10, NOS=5, COUNT=2; SWAP -> TOS=5, NOS=0x10; DUP -> TOS=5, NOS=5, COUNT=3.
- Alternate PUSH/POP on consecutive cycles at COUNT=2 and at DEPTH-1 -> no lost or duplicated entries; COUNT toggles correctly.
- Assert RST asynchronously (between edges) during a POP stream of 0xA0..0xA3 -> outputs zero immediately; after release, PUSH 0x55 -> TOS=0x55, NOS=0, COUNT=1.
